// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with optional 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/flush counters.
module pipe_stage_skid #(
  parameter int unsigned        DATA_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int unsigned        SKID      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  // Bit 0 is main_valid and bit 1 is skid_valid, so both come straight off flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              in_xfer;
  logic              out_xfer;

  assign out_valid = state_q[0];
  assign out_data  = main_data_q;
  assign in_ready  = (SKID != 0) ? in_ready_q : (!state_q[0] || out_ready);

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_data_d = RESET_VAL;
      skid_data_d = RESET_VAL;
    end else if (SKID != 0) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_data_d = in_data;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_ready) begin
            main_data_d = in_data;
          end else if (in_xfer) begin
            skid_data_d = in_data;
            state_d     = ST_SKID;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            main_data_d = skid_data_q;
            state_d     = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end else begin
      if (in_xfer) begin
        main_data_d = in_data;
        state_d     = ST_FULL;
      end else if (out_xfer) begin
        state_d = ST_EMPTY;
      end
    end
    // Registered ready: low exactly when the skid entry will be occupied.
    in_ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= RESET_VAL;
      skid_data_q <= RESET_VAL;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid (32-bit) and a no-skid (8-bit) instance share stimulus
// and are each compared against a queue-based reference model.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a;
  logic [31:0] out_data_a;
  logic        in_ready_b, out_valid_b;
  logic [7:0]  out_data_b;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
  logic [31:0] sc_m, fc_m;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] qa[$];
  logic [7:0]  qb[$];
  logic [31:0] hold_a;
  logic [7:0]  hold_b;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .SKID(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
`endif
  );

  pipe_stage_skid #(.DATA_W(8), .SKID(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data[7:0]),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    hold_a = '0;
    hold_b = '0;
`ifdef PIPE_STAGE_PERF_EN
    sc_m = '0;
    fc_m = '0;
`endif
  endtask

  // One cycle: drive at negedge, compare current outputs, advance the model to the next edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    bit a_in, a_out, b_in, b_out;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("a_out_valid", {31'd0, out_valid_a}, {31'd0, qa.size() > 0});
    chk("a_out_data",  out_data_a, hold_a);
    chk("a_in_ready",  {31'd0, in_ready_a}, {31'd0, qa.size() < 2});
    chk("b_out_valid", {31'd0, out_valid_b}, {31'd0, qb.size() > 0});
    chk("b_out_data",  {24'd0, out_data_b}, {24'd0, hold_b});
    chk("b_in_ready",  {31'd0, in_ready_b}, {31'd0, (qb.size() == 0) || ordy});
`ifdef PIPE_STAGE_PERF_EN
    chk("a_stall_cnt", stall_cnt_a, sc_m);
    chk("a_flush_cnt", flush_cnt_a, fc_m);
    if (qa.size() > 0 && !ordy && sc_m != 32'hFFFF_FFFF) sc_m++;
    if (fl && fc_m != 32'hFFFF_FFFF) fc_m++;
`endif
    a_in  = iv && (qa.size() < 2);
    a_out = (qa.size() > 0) && ordy;
    b_in  = iv && ((qb.size() == 0) || ordy);
    b_out = (qb.size() > 0) && ordy;
    if (fl) begin
      qa.delete();
      qb.delete();
      hold_a = '0;
      hold_b = '0;
    end else begin
      if (a_out) void'(qa.pop_front());
      if (a_in)  qa.push_back(d);
      if (qa.size() > 0) hold_a = qa[0];
      if (b_out) void'(qb.pop_front());
      if (b_in)  qb.push_back(d[7:0]);
      if (qb.size() > 0) hold_b = qb[0];
    end
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst_a_out_data",  out_data_a, 32'd0);
    chk("rst_a_in_ready",  {31'd0, in_ready_a}, 32'd1);
    chk("rst_b_in_ready",  {31'd0, in_ready_b}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    step(1, 32'h7, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("perf_stall5", stall_cnt_a, 32'd5);
    chk("perf_flush2", flush_cnt_a, 32'd2);
    @(negedge clk);
    force dut_a.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut_a.stall_cnt_q;
    sc_m = 32'hFFFF_FFFF;
    step(1, 32'h8, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("perf_sat", stall_cnt_a, 32'hFFFF_FFFF);
    repeat (3) step(0, 0, 1, 0);
`endif

    // Streaming at full rate
    step(1, 32'd1, 1, 0);
    step(1, 32'd2, 1, 0);
    chk("stream_d1", out_data_a, 32'd1);
    chk("stream_rdy", {31'd0, in_ready_a}, 32'd1);
    step(1, 32'd3, 1, 0);
    chk("stream_d2", out_data_a, 32'd2);
    step(0, 0, 1, 0);
    chk("stream_d3", out_data_a, 32'd3);
    step(0, 0, 1, 0);

    // Back-pressure into the skid entry
    step(1, 32'hA, 1, 0);
    step(1, 32'hB, 0, 0);
    chk("bp_main", out_data_a, 32'hA);
    step(0, 0, 0, 0);
    chk("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
    chk("bp_hold", out_data_a, 32'hA);
    step(0, 0, 1, 0);
    chk("bp_out_a", out_data_a, 32'hA);
    step(0, 0, 1, 0);
    chk("bp_out_b", out_data_a, 32'hB);
    chk("bp_rdy_back", {31'd0, in_ready_a}, 32'd1);
    step(0, 0, 1, 0);

    // Flush while both entries are held, with a concurrent offer
    step(1, 32'h5, 0, 0);
    step(1, 32'h6, 0, 0);
    step(1, 32'hC, 0, 1);
    chk("fl_in_ready", {31'd0, in_ready_a}, 32'd0);
    step(0, 0, 1, 0);
    chk("fl_out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("fl_out_data", out_data_a, 32'd0);
    repeat (2) step(0, 0, 1, 0);

    // Single-register stage: ready drops when held, replace without a bubble
    step(1, 32'h31, 0, 0);
    step(0, 0, 0, 0);
    chk("ns_in_ready_low", {31'd0, in_ready_b}, 32'd0);
    chk("ns_hold", {24'd0, out_data_b}, 32'h31);
    step(1, 32'h42, 1, 0);
    chk("ns_in_ready_hi", {31'd0, in_ready_b}, 32'd1);
    step(0, 0, 1, 0);
    chk("ns_replace_v", {31'd0, out_valid_b}, 32'd1);
    chk("ns_replace_d", {24'd0, out_data_b}, 32'h42);
    repeat (2) step(0, 0, 1, 0);

    // Asynchronous reset mid-cycle with entries held
    step(1, 32'h11, 0, 0);
    step(1, 32'h22, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("arst_a_valid", {31'd0, out_valid_a}, 32'd0);
    chk("arst_a_data",  out_data_a, 32'd0);
    chk("arst_a_ready", {31'd0, in_ready_a}, 32'd1);
    chk("arst_b_valid", {31'd0, out_valid_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end
    repeat (3) step(0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register that succeeds the fixed-field, enable-only inter-stage latches.
- Carries an opaque DATA_W-bit payload (pc+4, regfile write data/index, CP0 controls, halt, etc. packed by the instantiating stage).
- Uses a valid/ready handshake instead of a global enable, so stall back-pressure is local.
- Optional 2-entry skid buffer keeps in_ready fully registered at full throughput.
- Synchronous flush kills in-flight contents on branch/exception redirect.

Parameters:
DATA_W, 32, payload width in bits (>=1).
RESET_VAL, 0, value loaded into every data register on reset and on flush (DATA_W bits).
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  reset: asynchronous, active-high (asserted = 1), despite the name.
flush  in  1  synchronous kill of all held entries.
in_valid  in  1  upstream offers in_data.
in_ready  out  1  stage accepts in_data this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  out_data is valid.
out_ready  in  1  downstream consumes out_data this cycle.
out_data  out  DATA_W  payload to downstream.

Behaviour:
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Latency in->out is 1 cycle; sustained throughput is 1 transfer/cycle.
- Reset (rst_n=1, asynchronous):
  - main_valid=0, skid_valid=0.
  - main_data=skid_data=RESET_VAL.
  - out_valid=0, out_data=RESET_VAL.
  - in_ready=1 while in reset and on the first cycle after release.
  - Reset mid-operation discards all entries immediately.
- SKID=1: states EMPTY (main_valid=0), FULL (main only), SKID (main+skid).
  - in_ready = !skid_valid, a pure register output.
  - EMPTY: in_valid -> main<=in_data, go to FULL. Otherwise stay.
  - FULL, in_valid & out_ready: main<=in_data, stay FULL.
  - FULL, in_valid & !out_ready: skid<=in_data, go to SKID.
  - FULL, !in_valid & out_ready: go to EMPTY.
  - FULL, neither: hold.
  - SKID: in_ready=0.
  - SKID, out_ready: main<=skid, skid_valid<=0, go to FULL.
  - SKID, no out_ready: hold both entries.
  - Ordering is preserved: skid data always exits after main data.
- SKID=0: single register.
  - in_ready = !main_valid | out_ready (combinational).
  - Input transfer: main<=in_data, main_valid<=1.
  - Output transfer without input transfer: main_valid<=0.
- out_valid=main_valid and out_data=main_data, both driven directly from flops.
- While !out_ready & out_valid, out_data and out_valid must stay stable (no change until consumed).
- flush (priority over every transfer):
  - Next edge: main_valid=skid_valid=0, data registers<=RESET_VAL, state=EMPTY.
  - A concurrent input transfer is dropped; a concurrent output transfer still counts downstream.
  - in_ready during the flush cycle follows the normal rule.
- Entries never overflow: in SKID state in_ready=0 already, so in_valid there is ignored.
- Empty with out_ready=1 has no effect.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt [31:0] and flush_cnt [31:0].
  - stall_cnt increments each cycle out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1.
  - Both saturate at 32'hFFFF_FFFF and clear only on rst_n.
  - Both are registered; the value updates the edge after the event.
- Undefined: ports and counters are absent; datapath behaviour is identical.

Test Plan:
1. Reset: rst_n=1 asynchronously mid-cycle with entries held -> out_valid=0, out_data=0 immediately; in_ready=1.
2. Streaming, SKID=1, out_ready=1: in_data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each, in_ready stays 1.
3. Back-pressure: load 0xA, then out_ready=0 while offering 0xB -> skid fills, in_ready=0, out_data holds 0xA. Raise out_ready -> 0xA then 0xB out, in_ready=1 again.
4. Flush in SKID state with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=RESET_VAL, 0xC never appears.
5. SKID=0, DATA_W=8: out_ready=0 with an entry held -> in_ready=0. out_ready=1 with in_valid=1 -> simultaneous replace, no bubble.
6. PIPE_STAGE_PERF_EN: 5 stalled cycles plus 2 flush pulses -> stall_cnt=5, flush_cnt=2. Preload stall_cnt to 0xFFFF_FFFF -> stays saturated.
